// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared states, opcodes and select positions for the fetch sequencer
package fs_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RSTPC  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_DMEM   = 3'd4;
  localparam logic [2:0] ST_ADV    = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JREL = 4'h1;
  localparam logic [3:0] OP_JABS = 4'h2;
  localparam logic [3:0] OP_JR   = 4'h3;
  localparam logic [3:0] OP_BZ   = 4'h4;
  localparam logic [3:0] OP_LDM  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int SEL_W       = 5;
  localparam int SEL_RESETPC = 0;
  localparam int SEL_PCPLUSI = 1;
  localparam int SEL_PCPLUS1 = 2;
  localparam int SEL_IPLUS0  = 3;
  localparam int SEL_RPLUS0  = 4;

  typedef enum logic [1:0] {
    NK_FETCH = 2'd0,
    NK_DMEM  = 2'd1,
    NK_HALT  = 2'd2
  } next_kind_t;

  function automatic logic [SEL_W-1:0] onehot(input int pos);
    logic [SEL_W-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fs_decode.sv
// rtl/fs_decode.sv - opcode and zero flag to addressing-unit select, PC load and next step
module fs_decode
  import fs_pkg::*;
(
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  output logic [SEL_W-1:0] sel,
  output logic             pcen,
  output next_kind_t       next_kind
);

  // Unknown opcodes fall through to the NOP behaviour.
  always_comb begin
    sel       = onehot(SEL_PCPLUS1);
    pcen      = 1'b1;
    next_kind = NK_FETCH;
    case (opcode)
      OP_JREL: sel = onehot(SEL_PCPLUSI);
      OP_JABS: sel = onehot(SEL_IPLUS0);
      OP_JR:   sel = onehot(SEL_RPLUS0);
      OP_BZ:   sel = zero_flag ? onehot(SEL_PCPLUSI) : onehot(SEL_PCPLUS1);
      OP_LDM: begin
        sel       = onehot(SEL_RPLUS0);
        pcen      = 1'b0;
        next_kind = NK_DMEM;
      end
      OP_HALT: begin
        sel       = '0;
        pcen      = 1'b0;
        next_kind = NK_HALT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/execute sequencer driving the addressing unit selects
module fetch_sequencer
  import fs_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              zero_flag,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_rd,
  output logic              ResetPC,
  output logic              PCplusI,
  output logic              PCplus1,
  output logic              Iplus0,
  output logic              Rplus0,
  output logic              PCenable,
  output logic [IMM_W-1:0]  Iside,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ld_data,
  output logic              halted,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [SEL_W-1:0] dec_sel;
  logic [SEL_W-1:0] sel;
  logic             dec_pcen;
  next_kind_t       dec_kind;
  logic             waiting;
  logic             timeout;

  fs_decode u_decode (
    .opcode    (ir[DATA_W-1 -: 4]),
    .zero_flag (zero_flag),
    .sel       (dec_sel),
    .pcen      (dec_pcen),
    .next_kind (dec_kind)
  );

  assign mem_rd  = (state == ST_FETCH) || (state == ST_DMEM);
  assign halted  = (state == ST_HALTED);
  assign waiting = mem_rd && !mem_ready;
  // A ready arriving on the last allowed cycle is not a wait cycle, so it beats the timeout.
  assign timeout = waiting && (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    sel      = '0;
    PCenable = 1'b0;
    case (state)
      ST_RSTPC: begin
        sel      = onehot(SEL_RESETPC);
        PCenable = 1'b1;
      end
      ST_EXEC: begin
        sel      = dec_sel;
        PCenable = dec_pcen;
      end
      ST_DMEM: sel = onehot(SEL_RPLUS0);
      ST_ADV: begin
        sel      = onehot(SEL_PCPLUS1);
        PCenable = 1'b1;
      end
      default: ;
    endcase
  end

  assign ResetPC = sel[SEL_RESETPC];
  assign PCplusI = sel[SEL_PCPLUSI];
  assign PCplus1 = sel[SEL_PCPLUS1];
  assign Iplus0  = sel[SEL_IPLUS0];
  assign Rplus0  = sel[SEL_RPLUS0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ir       <= '0;
      Iside    <= '0;
      ld_data  <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;

      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state   <= ST_RSTPC;
            bus_err <= 1'b0;
          end
        end
        ST_RSTPC: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_data;
            Iside <= mem_data[IMM_W-1:0];
            state <= ST_EXEC;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= ST_HALTED;
          end
        end
        ST_EXEC: begin
          case (dec_kind)
            NK_DMEM: state <= ST_DMEM;
            NK_HALT: state <= ST_HALTED;
            default: state <= ST_FETCH;
          endcase
        end
        ST_DMEM: begin
          if (mem_ready) begin
            ld_data <= mem_data;
            state   <= ST_ADV;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= ST_HALTED;
          end
        end
        ST_ADV:  state <= ST_FETCH;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
